// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: synchronises the receiver strobe, strips E0/F0 prefixes
// and queues decoded key events. Optional prefix timeout under PS2_TIMEOUT_EN.
module ps2_scan_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_e;

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;
  logic byte_stb;

  state_e state_q, state_d;
  logic   push;
  ev_t    push_ev;
  logic   timeout_hit;
  logic   is_prefix;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ev_t              mem_q [FIFO_DEPTH];
  ev_t              head_q, head_d;
  logic             ev_valid_q, ev_valid_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             pop, full, wr_en, ovf_set;

  // Rising-edge detect on the synchronised byte-valid level.
  always_comb begin
    s1_d = rx_valid;
    s2_d = s1_q;
    s3_d = s2_q;
  end
  assign byte_stb  = s2_q & ~s3_q;
  assign is_prefix = (rx_data == CODE_EXT) || (rx_data == CODE_BRK);

`ifdef PS2_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (state_q == S_IDLE || byte_stb) to_cnt_d = '0;
  end
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!RST) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TO_W'(TIMEOUT_CYCLES)};
  assign timeout_hit = 1'b0;
`endif

  // Prefix FSM: a received byte is processed before any pending timeout.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    push_ev = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (byte_stb) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == CODE_EXT)      state_d = S_EXT;
          else if (rx_data == CODE_BRK) state_d = S_BRK;
          else                          push    = 1'b1;
        end
        S_EXT: begin
          if (rx_data == CODE_BRK)      state_d = S_EXTBRK;
          else if (rx_data != CODE_EXT) begin
            push        = 1'b1;
            push_ev.ext = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_BRK: begin
          push        = ~is_prefix;
          push_ev.brk = 1'b1;
          state_d     = S_IDLE;
        end
        S_EXTBRK: begin
          push        = ~is_prefix;
          push_ev.ext = 1'b1;
          push_ev.brk = 1'b1;
          state_d     = S_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // Event FIFO; a full push is still accepted when a pop frees a slot the same cycle.
  always_comb begin
    pop      = ev_valid_q & ev_ready;
    full     = (cnt_q == FULL_CNT);
    wr_en    = push & (~full | pop);
    ovf_set  = push & full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);
    head_d = '0;
    if (cnt_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = push_ev;
      else                                 head_d = mem_q[rd_ptr_d];
    end
    ev_valid_d = (cnt_d != '0);
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      s3_q       <= 1'b1;
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      ev_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      ev_valid_q <= ev_valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_ev;
  end

  assign ev_valid = ev_valid_q;
  assign ev_code  = head_q.code;
  assign ev_ext   = head_q.ext;
  assign ev_break = head_q.brk;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: directed scenarios with literal expectations plus a random
// byte stream, all checked every cycle against a queue-based event model.
module tb_ps2_scan_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TO_CYC = 20;
  localparam int unsigned TOW    = 8;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow, busy;
  logic [7:0] ev_code;

  int  tests = 0;
  int  fails = 0;
  bit  rnd = 1'b0;

  ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC), .TO_W(TOW)) dut (
    .clk(clk), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: rx_valid samples of recent edges, pending prefix flags, event queue.
  bit        v1 = 1'b1, v2 = 1'b1, v3 = 1'b1;
  bit        m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
  int        m_to = 0;
  bit [9:0]  mq[$];

  function automatic bit is_pfx(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0);
  endfunction

  always @(posedge clk) begin
    bit stb, pend, pop, do_push, full;
    bit [9:0] pe;
    if (!RST) begin
      v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_to = 0;
      mq.delete();
    end else begin
      stb     = v2 & ~v3;
      pend    = m_ext | m_brk;
      pop     = (mq.size() != 0) && ev_ready;
      full    = (mq.size() == DEPTH);
      do_push = 1'b0;
      pe      = '0;
      if (stb) begin
        if (m_brk) begin
          if (!is_pfx(rx_data)) begin do_push = 1'b1; pe = {m_ext, 1'b1, rx_data}; end
          m_ext = 1'b0; m_brk = 1'b0;
        end else if (rx_data == 8'hE0) m_ext = 1'b1;
        else if (rx_data == 8'hF0) m_brk = 1'b1;
        else begin do_push = 1'b1; pe = {m_ext, 1'b0, rx_data}; m_ext = 1'b0; end
      end
`ifdef PS2_TIMEOUT_EN
      else if (pend && m_to == TO_CYC) begin m_ext = 1'b0; m_brk = 1'b0; end
      m_to = (!pend || stb) ? 0 : m_to + 1;
`endif
      if (pop) void'(mq.pop_front());
      if (ovf_clr) m_ovf = 1'b0;
      if (do_push) begin
        if (full && !pop) m_ovf = 1'b1;
        else mq.push_back(pe);
      end
      v3 = v2; v2 = v1; v1 = rx_valid;
    end
  end

  always @(negedge clk) begin
    bit [9:0] h;
    h = (mq.size() != 0) ? mq[0] : 10'h000;
    chk("outputs{valid,ext,brk,code,ovf,busy}",
        32'({ev_valid, ev_ext, ev_break, ev_code, overflow, busy}),
        32'({mq.size() != 0, h[9], h[8], h[7:0], m_ovf, m_ext | m_brk}));
  end

  task automatic tick();
    if (rnd) begin
      ev_ready = 1'($urandom_range(0, 1));
      ovf_clr  = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] ovc [5];
    logic [7:0] b;
    ovc = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ev_valid, ev_code, ev_ext, ev_break, overflow, busy}), 32'h0);
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // Single make code, latency and one-shot strobe.
    ev_ready = 1'b1;
    rx_data = 8'h1C; rx_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("make_not_before_edge3", 32'(ev_valid), 32'h0);
    @(negedge clk);
    chk("make_valid_after_edge3", 32'(ev_valid), 32'h1);
    chk("make_event", 32'({ev_code, ev_ext, ev_break}), 32'({8'h1C, 2'b00}));
    n = 1;
    repeat (197) begin @(negedge clk); if (ev_valid) n++; end
    rx_valid = 1'b0;
    repeat (5) begin @(negedge clk); if (ev_valid) n++; end
    chk("make_valid_cycles", 32'(n), 32'd1);

    // Extended break sequence.
    ev_ready = 1'b0;
    send(8'hE0, 3, 4);
    chk("extbrk_busy1", 32'(busy), 32'h1);
    send(8'hF0, 3, 4);
    chk("extbrk_busy2", 32'(busy), 32'h1);
    send(8'h74, 3, 4);
    chk("extbrk_event", 32'({ev_valid, ev_code, ev_ext, ev_break, busy}), 32'({1'b1, 8'h74, 3'b110}));
    pop_one();
    chk("extbrk_drained", 32'(ev_valid), 32'h0);

    // Overflow with ev_ready low.
    for (int i = 0; i < 5; i++) send(ovc[i], 2, 4);
    chk("ovf_set", 32'({ev_valid, overflow}), 32'h3);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_order", 32'(ev_code), 32'(ovc[i]));
      pop_one();
    end
    chk("ovf_drained", 32'(ev_valid), 32'h0);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO, push coincides with pop.
    for (int i = 1; i <= 4; i++) send(8'(i), 2, 4);
    rx_data = 8'h05; rx_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      chk("full_pushpop_order", 32'(ev_code), 32'(i));
      pop_one();
    end
    chk("full_pushpop_drained", 32'(ev_valid), 32'h0);

    // Prefix timeout, then protocol error.
    send(8'hF0, 2, TO_CYC + 5);
    send(8'h1C, 2, 4);
`ifdef PS2_TIMEOUT_EN
    chk("timeout_event", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h1C, 2'b00}));
`else
    chk("no_timeout_event", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h1C, 2'b01}));
`endif
    pop_one();
    send(8'hF0, 2, 4);
    send(8'hE0, 2, 4);
    chk("proto_err", 32'({ev_valid, busy}), 32'h0);

    // Reset mid-prefix with a byte held valid.
    send(8'hF0, 2, 4);
    rx_data = 8'h33; rx_valid = 1'b1; RST = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_held", 32'({ev_valid, ev_code, ev_ext, ev_break, overflow, busy}), 32'h0);
    end
    RST = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_reset", 32'({ev_valid, ev_code, ev_ext, ev_break, overflow, busy}), 32'h0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h44, 2, 4);
    chk("fresh_after_reset", 32'({ev_valid, ev_code, ev_ext, ev_break}), 32'({1'b1, 8'h44, 2'b00}));
    pop_one();

    // Random byte stream with random ready and overflow clears.
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4: begin
          case ($urandom_range(0, 4))
            0: b = 8'hAA; 1: b = 8'hFA; 2: b = 8'hFE; 3: b = 8'h00; default: b = 8'hFF;
          endcase
        end
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b, $urandom_range(1, 4), $urandom_range(2, 6));
    end
    rnd = 1'b0;
    ev_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Scan-code sequencer that sits between the PS/2 serial receiver and the keyboard consumer logic. It synchronises the receiver's byte-valid level into the `clk` domain and captures each received byte exactly once. It strips the `E0` extended and `F0` break prefixes and pushes one decoded key event per key into a small FIFO. Consumers drain that FIFO through a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of 2, ≥2.
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles a pending prefix may wait for its next byte.
- `TO_W`, default 16: timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.
- `clk` in 1: system clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `rx_valid` in 1: receiver byte-valid level, asynchronous to `clk`. It stays high until the next frame starts.
- `rx_data` in 8: receiver byte, LSB = first bit on the wire. Stable while `rx_valid` is high.
- `ev_valid` out 1: FIFO holds at least one event.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 8: head event scan code.
- `ev_ext` out 1: head event was `E0`-prefixed.
- `ev_break` out 1: head event was `F0`-prefixed (key release).
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `overflow`.
- `busy` out 1: prefix FSM not in IDLE.

## Operation
- **Synchroniser:** 3-flop chain `s1→s2→s3` on `rx_valid`.
  - `byte_stb = s2 & ~s3`.
  - `rx_data` is sampled in the same cycle that `byte_stb` is high.
  - A level held high for any duration yields exactly one strobe.
- **Prefix FSM**, states IDLE, EXT, BRK, EXTBRK. It advances only on `byte_stb`.
  - IDLE:
    - `E0` → EXT.
    - `F0` → BRK.
    - Other byte → push {ext=0, brk=0, code}; stay in IDLE.
  - EXT:
    - `F0` → EXTBRK.
    - `E0` → stay in EXT.
    - Other byte → push {1, 0, code}; go to IDLE.
  - BRK:
    - `E0` or `F0` → protocol error: drop the byte, no push, go to IDLE.
    - Other byte → push {0, 1, code}; go to IDLE.
  - EXTBRK:
    - `E0` or `F0` → protocol error: drop the byte, no push, go to IDLE.
    - Other byte → push {1, 1, code}; go to IDLE.
  - All other codes (`AA`, `FA`, `FE`, `00`, `FF`) are pushed as ordinary events.
- **FIFO:** circular buffer with read/write pointers and a count.
  - `pop = ev_valid & ev_ready`.
  - Push when full with no pop in the same cycle: the event is dropped and `overflow` is set.
  - Push when full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Push and pop when not full: the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Head outputs:**
  - `ev_code`, `ev_ext` and `ev_break` show the head entry and read 0 when the FIFO is empty.
  - They must not change while `ev_valid=1` and `ev_ready=0`.
- **Overflow:** `ovf_clr` clears `overflow`. If `ovf_clr` coincides with an overflow event, the set wins.
- **Reset (`RST=0` at a clock edge):**
  - FSM to IDLE; FIFO empty; timeout counter 0; `overflow` 0.
  - `s1`, `s2` and `s3` are set to 1, so a byte still held valid across reset is never captured.
  - Output values during reset: `ev_valid` 0, `ev_code` 0, `ev_ext` 0, `ev_break` 0, `overflow` 0, `busy` 0.
  - A reset mid-prefix discards the prefix.

## Timing
- Latency from `rx_valid` rising to `ev_valid`:
  - Edge 1: rising `rx_valid` sampled into `s1`.
  - Edge 2: reaches `s2`; `byte_stb` is high in the following cycle.
  - Edge 3: the FIFO write occurs.
  - `ev_valid` is high after edge 3 when the FIFO was empty.
- `ev_valid` drops the cycle after the pop of the last entry.
- Throughput: one event per cycle on both push and pop. PS/2 byte rate is far below this.
- `busy` is registered and reflects the FSM state after each edge.

## Configuration
- `PS2_TIMEOUT_EN` defined:
  - A counter increments every cycle while the FSM is not IDLE and clears on `byte_stb` or in IDLE.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE on the next edge, the pending prefix is discarded, and nothing is pushed.
  - If `byte_stb` arrives in the same cycle, the byte is processed first and the timeout is ignored.
- `PS2_TIMEOUT_EN` undefined: no counter is instantiated and a prefix waits indefinitely.

## Test plan
- Basic make code:
  - Stimulus: `rx_valid` rises with `rx_data=1C`, held for 200 cycles, `ev_ready=1`.
  - Response: one event {1C, ext 0, break 0}; `ev_valid` high exactly 1 cycle, first high after edge 3.
- Extended break sequence:
  - Stimulus: byte sequence `E0`, `F0`, `74`.
  - Response: a single event {74, 1, 1}; `busy` is 1 between bytes.
- FIFO overflow:
  - Stimulus: five make codes `15`, `1D`, `24`, `2D`, `2C` with `ev_ready=0`.
  - Response: 4 events held, `overflow=1`, `2C` lost.
  - Stimulus: drain the FIFO.
  - Response: `15`, `1D`, `24`, `2D` in that order.
  - Stimulus: pulse `ovf_clr`.
  - Response: `overflow=0`.
- Full FIFO with simultaneous push and pop:
  - Stimulus: FIFO full, push arrives in the same cycle as a pop.
  - Response: count remains 4 and `overflow` stays 0.
- Prefix timeout and protocol error:
  - Stimulus: byte `F0`, then idle for `TIMEOUT_CYCLES + 5` cycles, then byte `1C`.
  - Response with `PS2_TIMEOUT_EN`: event {1C, 0, 0}. Without it: event {1C, 0, 1}.
  - Stimulus: bytes `F0`, `E0`.
  - Response: no event, FSM returns to IDLE.
- Reset with a held byte:
  - Stimulus: `RST=0` for 3 cycles while `rx_valid=1`, then release.
  - Response: no event; all outputs read 0 during and after reset.
  - Stimulus: next fresh `rx_valid` rising edge.
  - Response: captured normally.
